// File: rtl/net_inject_unit.sv
// rtl/net_inject_unit.sv - ring-network injection stage: header build, 2-entry queue, credit flow control
module net_inject_unit #(
  parameter int p_payload_nbits = 32,
  parameter int p_max_credits   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 terminal_id,
  input  logic                       req_val,
  output logic                       req_rdy,
  input  logic [1:0]                 req_dest,
  input  logic [p_payload_nbits-1:0] req_payload,
  output logic [11:0]                out_msg_hdr,
  output logic [p_payload_nbits-1:0] out_msg_payload,
  output logic                       out_val,
  input  logic                       out_rdy,
  input  logic                       ack_val,
  output logic [3:0]                 credits,
  output logic [15:0]                num_sent,
  output logic                       err_ack
);

  localparam logic [3:0] MAX_CRED = 4'(p_max_credits);

  typedef struct packed {
    logic [11:0]                hdr;
    logic [p_payload_nbits-1:0] payload;
  } msg_t;

  msg_t        ent_q [2];
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, rd_ptr_q;
  logic [3:0]  credits_q, credits_d;
  logic [7:0]  seq_q [4];
  logic [15:0] num_sent_q;
  logic        err_ack_q, err_ack_d;

  logic full, empty, accept, deq;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  // Gated by the raw reset input so no request is taken while reset is held.
  assign req_rdy = reset && !full && (credits_q != 4'd0);
  assign accept  = req_val && req_rdy;
  assign out_val = !empty;
  assign deq     = out_val && out_rdy;

  assign out_msg_hdr     = ent_q[rd_ptr_q].hdr;
  assign out_msg_payload = ent_q[rd_ptr_q].payload;
  assign credits         = credits_q;
  assign num_sent        = num_sent_q;
  assign err_ack         = err_ack_q;

  always_comb begin
    count_d   = count_q;
    credits_d = credits_q;
    err_ack_d = err_ack_q;
    case ({accept, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // An accept and an ack in the same cycle cancel out.
    if (accept && !ack_val) begin
      credits_d = credits_q - 4'd1;
    end else if (!accept && ack_val) begin
      if (credits_q < MAX_CRED) credits_d = credits_q + 4'd1;
      else                      err_ack_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      credits_q  <= MAX_CRED;
      num_sent_q <= 16'd0;
      err_ack_q  <= 1'b0;
      for (int i = 0; i < 4; i++) seq_q[i] <= 8'd0;
    end else begin
      count_q   <= count_d;
      credits_q <= credits_d;
      err_ack_q <= err_ack_d;
      if (accept) begin
        wr_ptr_q        <= !wr_ptr_q;
        seq_q[req_dest] <= seq_q[req_dest] + 8'd1;
      end
      if (deq) begin
        rd_ptr_q   <= !rd_ptr_q;
        num_sent_q <= num_sent_q + 16'd1;
      end
    end
  end

  // Queue storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      ent_q[wr_ptr_q] <= '{hdr: {req_dest, terminal_id, seq_q[req_dest]},
                           payload: req_payload};
    end
  end

endmodule

// File: tb/tb_net_inject_unit.sv
// tb/tb_net_inject_unit.sv - vector table, corner sequences and random model check for net_inject_unit
module tb_net_inject_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  terminal_id;
  logic        req_val;
  logic        req_rdy;
  logic [1:0]  req_dest;
  logic [31:0] req_payload;
  logic [11:0] out_msg_hdr;
  logic [31:0] out_msg_payload;
  logic        out_val;
  logic        out_rdy;
  logic        ack_val;
  logic [3:0]  credits;
  logic [15:0] num_sent;
  logic        err_ack;

  int n_tests = 0;
  int n_fail  = 0;

  net_inject_unit #(.p_payload_nbits(32), .p_max_credits(4)) dut (
    .clk(clk), .reset(reset), .terminal_id(terminal_id),
    .req_val(req_val), .req_rdy(req_rdy), .req_dest(req_dest), .req_payload(req_payload),
    .out_msg_hdr(out_msg_hdr), .out_msg_payload(out_msg_payload),
    .out_val(out_val), .out_rdy(out_rdy), .ack_val(ack_val),
    .credits(credits), .num_sent(num_sent), .err_ack(err_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [1:0]  dst;
    logic [31:0] pl;
    logic        ordy;
    logic        ack;
    logic        e_rdy;
    logic        e_val;
    logic [11:0] e_hdr;
    logic [31:0] e_pl;
    logic [3:0]  e_cred;
    logic [15:0] e_ns;
  } vec_t;

  typedef struct packed {
    logic [11:0] h;
    logic [31:0] p;
  } m_t;

  vec_t tbl [19];

  function automatic vec_t mk(logic rv, logic [1:0] dst, logic [31:0] pl, logic ordy, logic ack,
                              logic e_rdy, logic e_val, logic [11:0] e_hdr, logic [31:0] e_pl,
                              logic [3:0] e_cred, logic [15:0] e_ns);
    vec_t v;
    v.rv = rv; v.dst = dst; v.pl = pl; v.ordy = ordy; v.ack = ack;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_hdr = e_hdr; v.e_pl = e_pl;
    v.e_cred = e_cred; v.e_ns = e_ns;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [1:0] dst, input logic [31:0] pl,
                       input logic ordy, input logic ack);
    req_val = rv; req_dest = dst; req_payload = pl; out_rdy = ordy; ack_val = ack;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] tid);
    terminal_id = tid;
    reset = 1'b0;
    drive(1'b1, 2'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rdy_in_reset", 64'(req_rdy), 64'd0);
    next_cycle();
    reset = 1'b1;
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // One send to 'dst' per cycle, out_rdy high; the ack keeps credits level.
  task automatic send_acked(input logic [1:0] dst, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, dst, 32'(i), 1'b1, 1'b1);
      @(negedge clk);
      chk("loop_rdy", 64'(req_rdy), 64'd1);
      next_cycle();
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 3, 32'hDEADBEEF, 1, 0, 1, 0, 12'h000, 32'h0,        4, 0);
    tbl[1]  = mk(0, 0, 32'h0,        1, 0, 1, 1, 12'hD00, 32'hDEADBEEF, 3, 0);
    tbl[2]  = mk(0, 0, 32'h0,        1, 0, 1, 0, 12'h000, 32'h0,        3, 1);
    tbl[3]  = mk(1, 2, 32'hA1A1A1A1, 0, 0, 1, 0, 12'h000, 32'h0,        3, 1);
    tbl[4]  = mk(1, 2, 32'hA2A2A2A2, 0, 0, 1, 1, 12'h900, 32'hA1A1A1A1, 2, 1);
    tbl[5]  = mk(1, 0, 32'hA3A3A3A3, 0, 0, 0, 1, 12'h900, 32'hA1A1A1A1, 1, 1);
    tbl[6]  = mk(1, 0, 32'hA3A3A3A3, 0, 0, 0, 1, 12'h900, 32'hA1A1A1A1, 1, 1);
    tbl[7]  = mk(0, 0, 32'h0,        1, 0, 0, 1, 12'h900, 32'hA1A1A1A1, 1, 1);
    tbl[8]  = mk(0, 0, 32'h0,        1, 0, 1, 1, 12'h901, 32'hA2A2A2A2, 1, 2);
    tbl[9]  = mk(0, 0, 32'h0,        1, 0, 1, 0, 12'h000, 32'h0,        1, 3);
    tbl[10] = mk(0, 0, 32'h0,        1, 1, 1, 0, 12'h000, 32'h0,        1, 3);
    tbl[11] = mk(1, 1, 32'hB0B0B0B0, 1, 1, 1, 0, 12'h000, 32'h0,        2, 3);
    tbl[12] = mk(1, 1, 32'hB1B1B1B1, 1, 0, 1, 1, 12'h500, 32'hB0B0B0B0, 2, 3);
    tbl[13] = mk(1, 1, 32'hB2B2B2B2, 1, 0, 1, 1, 12'h501, 32'hB1B1B1B1, 1, 4);
    tbl[14] = mk(1, 1, 32'hB3B3B3B3, 1, 0, 0, 1, 12'h502, 32'hB2B2B2B2, 0, 5);
    tbl[15] = mk(1, 1, 32'hB3B3B3B3, 1, 1, 0, 0, 12'h000, 32'h0,        0, 6);
    tbl[16] = mk(1, 1, 32'hB3B3B3B3, 1, 0, 1, 0, 12'h000, 32'h0,        1, 6);
    tbl[17] = mk(0, 0, 32'h0,        1, 0, 0, 1, 12'h503, 32'hB3B3B3B3, 0, 6);
    tbl[18] = mk(0, 0, 32'h0,        1, 0, 0, 0, 12'h000, 32'h0,        0, 7);

    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    terminal_id = 2'd1;
    reset = 1'b0;
    #1;
    do_reset(2'd1);

    @(negedge clk);
    chk("rst_val", 64'(out_val), 64'd0);
    chk("rst_cred", 64'(credits), 64'd4);
    chk("rst_ns", 64'(num_sent), 64'd0);
    chk("rst_err", 64'(err_ack), 64'd0);
    chk("rst_rdy", 64'(req_rdy), 64'd1);
    next_cycle();

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rv, tbl[i].dst, tbl[i].pl, tbl[i].ordy, tbl[i].ack);
      @(negedge clk);
      chk($sformatf("v%0d_rdy", i), 64'(req_rdy), 64'(tbl[i].e_rdy));
      chk($sformatf("v%0d_val", i), 64'(out_val), 64'(tbl[i].e_val));
      chk($sformatf("v%0d_cred", i), 64'(credits), 64'(tbl[i].e_cred));
      chk($sformatf("v%0d_ns", i), 64'(num_sent), 64'(tbl[i].e_ns));
      chk($sformatf("v%0d_err", i), 64'(err_ack), 64'd0);
      if (tbl[i].e_val) begin
        chk($sformatf("v%0d_hdr", i), 64'(out_msg_hdr), 64'(tbl[i].e_hdr));
        chk($sformatf("v%0d_pl", i), 64'(out_msg_payload), 64'(tbl[i].e_pl));
      end
      next_cycle();
    end

    // Ack with full credits sets the sticky error; reset clears it.
    do_reset(2'd1);
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b1, 2'd3, 32'h1234, 1'b1, 1'b0);
    @(negedge clk);
    chk("ovf_cred", 64'(credits), 64'd4);
    chk("ovf_err", 64'(err_ack), 64'd1);
    next_cycle();
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("ovf_err_sticky", 64'(err_ack), 64'd1);
    chk("ovf_ns", 64'(num_sent), 64'd1);
    next_cycle();
    do_reset(2'd1);
    @(negedge clk);
    chk("ovf_err_clr", 64'(err_ack), 64'd0);
    next_cycle();

    // Sequence wrap: 256 sends to dest 2, the next carries opaque 0x00.
    send_acked(2'd2, 256);
    drive(1'b1, 2'd2, 32'hCAFE0101, 1'b1, 1'b0);
    @(negedge clk);
    chk("wrap_hdr255", 64'(out_msg_hdr), 64'h9FF);
    next_cycle();
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("wrap_hdr0", 64'(out_msg_hdr), 64'h900);
    chk("wrap_pl", 64'(out_msg_payload), 64'hCAFE0101);
    chk("wrap_ns", 64'(num_sent), 64'd256);
    next_cycle();
    next_cycle();

    // Reset mid-operation: seq[1]=5, two queued, credits=2.
    do_reset(2'd1);
    send_acked(2'd1, 5);
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 2'd0, 32'h11, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 2'd0, 32'h22, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_cred", 64'(credits), 64'd2);
    chk("mid_val", 64'(out_val), 64'd1);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_val", 64'(out_val), 64'd0);
    chk("mid_rst_cred", 64'(credits), 64'd4);
    chk("mid_rst_ns", 64'(num_sent), 64'd0);
    next_cycle();
    drive(1'b1, 2'd1, 32'h77, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mid_seq_hdr", 64'(out_msg_hdr), 64'h500);
    next_cycle();

    // Randomised traffic against a queue-based reference model.
    begin
      m_t         mq[$];
      logic [7:0] mseq [4];
      int         mcred;
      int         mns;
      logic       merr;
      logic [1:0] tid;
      tid = 2'($urandom_range(0, 3));
      do_reset(tid);
      for (int d = 0; d < 4; d++) mseq[d] = 8'd0;
      mcred = 4; mns = 0; merr = 1'b0;
      for (int c = 0; c < 400; c++) begin
        logic       rv, ordy, ack, e_rdy, e_val, acc, dq;
        logic [1:0] dst;
        logic [31:0] pl;
        rv   = ($urandom_range(0, 3) != 0);
        dst  = 2'($urandom_range(0, 3));
        pl   = $urandom;
        ordy = ($urandom_range(0, 2) != 0);
        ack  = ($urandom_range(0, 3) == 0);
        drive(rv, dst, pl, ordy, ack);
        e_rdy = (mq.size() < 2) && (mcred != 0);
        e_val = (mq.size() != 0);
        @(negedge clk);
        chk("rnd_rdy", 64'(req_rdy), 64'(e_rdy));
        chk("rnd_val", 64'(out_val), 64'(e_val));
        chk("rnd_cred", 64'(credits), 64'(mcred));
        chk("rnd_ns", 64'(num_sent), 64'(mns));
        chk("rnd_err", 64'(err_ack), 64'(merr));
        if (e_val) begin
          chk("rnd_hdr", 64'(out_msg_hdr), 64'(mq[0].h));
          chk("rnd_pl", 64'(out_msg_payload), 64'(mq[0].p));
        end
        acc = rv && e_rdy;
        dq  = e_val && ordy;
        if (dq) begin
          void'(mq.pop_front());
          mns = (mns + 1) % 65536;
        end
        if (acc) begin
          mq.push_back({dst, tid, mseq[dst], pl});
          mseq[dst] = mseq[dst] + 8'd1;
        end
        if (acc && !ack) mcred = mcred - 1;
        else if (!acc && ack) begin
          if (mcred < 4) mcred = mcred + 1;
          else merr = 1'b1;
        end
        next_cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/net_inject_unit.md
Name: net_inject_unit

Overview:
- Terminal-side injection stage that feeds one input port of the 4-terminal ring network.
- Accepts raw requests (destination and 32-bit payload) from a terminal. Builds the 12-bit network header {dest[1:0], src[1:0], opaque[7:0]}, where opaque is a per-destination sequence number.
- Buffers messages in a 2-entry queue and drives the network input val/rdy port.
- Limits in-flight messages with a credit counter, replenished by delivery acks from the ejection side.

Parameters:
- p_payload_nbits, 32, payload width in bits.
- p_max_credits, 4, maximum un-acked messages in flight (1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk edge).
- terminal_id  input  2  this terminal's id; static after reset; used as header src.
- req_val  input  1  request valid.
- req_rdy  output  1  request ready.
- req_dest  input  2  destination terminal.
- req_payload  input  p_payload_nbits  request payload.
- out_msg_hdr  output  12  header to network: [11:10] dest, [9:8] src, [7:0] opaque.
- out_msg_payload  output  p_payload_nbits  payload to network.
- out_val  output  1  network-side valid.
- out_rdy  input  1  network-side ready (router in1_rdy).
- ack_val  input  1  one-cycle pulse: one message from this source was delivered.
- credits  output  4  current credit count.
- num_sent  output  16  count of out_val&&out_rdy handshakes; wraps 0xFFFF->0.
- err_ack  output  1  sticky: ack received while credits == p_max_credits.

Behaviour:
- Reset (reset==0 at edge):
  - queue emptied; out_val=0; credits=p_max_credits; all four seq[d]=0; num_sent=0; err_ack=0.
  - req_rdy is forced 0 while reset==0.
  - Reset mid-operation discards queued messages and in-flight credit state, with no drain.
- req_rdy is combinational: (queue not full) && (credits != 0) && reset==1. It never depends on req_val.
- Accept: fires when req_val && req_rdy. On the accept edge:
  - enqueue {req_dest, terminal_id, seq[req_dest], req_payload};
  - seq[req_dest] <= seq[req_dest]+1, mod 256; other seq entries unchanged;
  - dest == terminal_id (loopback) is legal and handled identically.
- Queue: 2 entries, normal (no bypass, no pipe).
  - An accepted message appears at out_* in the next cycle at the earliest (latency 1).
  - out_val = queue not empty; out_* shows the head entry.
  - Head is stable while out_val && !out_rdy.
  - Simultaneous enq and deq on a full queue is not allowed: req_rdy is 0 when full.
  - Enq and deq in the same cycle with 1 entry leaves 1 entry.
  - FIFO order is strict.
- Credits, next value:
  - accept && !ack_val: credits-1.
  - !accept && ack_val && credits<p_max_credits: credits+1.
  - accept && ack_val: unchanged.
  - !accept && ack_val && credits==p_max_credits: unchanged, and err_ack <= 1.
  - credits==0 blocks req_rdy even when the queue has space.
  - An ack in the same cycle as credits==0 does not raise req_rdy until the next cycle, because req_rdy uses the registered credits.
- num_sent increments by 1 on each out_val && out_rdy edge.
- err_ack stays 1 until reset. It has no effect on the datapath.
- All outputs are registered or derived from registered state, except req_rdy, which also depends on the reset input.

Test Plan:
- Basic inject: terminal_id=1, p_max_credits=4, out_rdy=1. Send dest=3, payload=0xDEADBEEF at cycle 0 -> at cycle 1 out_val=1, out_msg_hdr=0xD00 ({3,1,0x00}), payload 0xDEADBEEF; num_sent=1 after the handshake; credits=3.
- Per-dest sequencing: send dests 2,2,0,2 with acks keeping credits up -> opaques 0x00,0x01,0x00,0x02 in order. Also preload seq[2]=255 via 256 sends to dest 2 -> the 257th carries opaque 0x00 (wrap).
- Backpressure/full: out_rdy=0, send 3 requests -> the first two accepted; req_rdy=0 from the cycle after the second; head hdr/payload stable. Raise out_rdy -> drain in FIFO order, req_rdy returns to 1.
- Credit exhaustion: p_max_credits=4, no acks, out_rdy=1 -> 4 accepted, credits=0, req_rdy=0. Pulse ack_val once -> credits=1 next cycle, req_rdy=1, one more accept. Accept and ack in the same cycle -> credits unchanged.
- Ack overflow: after reset (credits=4), pulse ack_val -> credits stays 4, err_ack=1 and stays 1 across later traffic; an active-low reset pulse clears it to 0.
- Reset mid-operation: 2 queued, credits=2, seq[1]=5; drive reset=0 for one edge -> out_val=0, credits=4, seq all 0, num_sent=0. The next send to dest 1 carries opaque 0x00.
